uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the controller state encoding and the default frame/requester/timeout sizes.
package uart_pkg;

   localparam int unsigned DEF_N       = 8;
   localparam int unsigned DEF_NREQ    = 4;
   localparam int unsigned DEF_TIMEOUT = 16;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   // Index width for a requester count; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above the pointer, with wrap.
// Returns a one-hot grant, the winning index and whether anyone is requesting.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NREQ = DEF_NREQ
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [idx_w(NREQ)-1:0]  rr_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [idx_w(NREQ)-1:0]  idx_o,
   output logic                    any_o
);

   localparam int unsigned IW = idx_w(NREQ);

   function automatic int wrap_idx(input logic [IW-1:0] base, input int off);
      return (int'(base) + off) % int'(NREQ);
   endfunction

   // Offset k is scanned outward from the pointer; the first hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int k = 0; k < int'(NREQ); k++) begin
         for (int p = 0; p < int'(NREQ); p++) begin
            if (!any_o && (p == wrap_idx(rr_i, k)) && req_i[p]) begin
               any_o    = 1'b1;
               gnt_o[p] = 1'b1;
               idx_o    = IW'(p);
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NREQ requesters: round-robin grant, start pulse,
// busy handshake with a no-response timeout, and a done pulse per completed frame.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned N       = DEF_N,
   parameter int unsigned NREQ    = DEF_NREQ,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic                    sysclk,
   input  logic                    reset_n,
   input  logic [NREQ-1:0]         req_valid_i,
   input  logic [NREQ*N-1:0]       req_data_i,
   output logic [NREQ-1:0]         req_ready_o,
   output logic                    tx_start_o,
   output logic [N-1:0]            tx_data_o,
   input  logic                    tx_busy_i,
   output logic                    done_o,
   output logic [idx_w(NREQ)-1:0]  done_id_o,
   output logic                    err_timeout_o
);

   localparam int unsigned IW = idx_w(NREQ);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   state_t          r_state;
   state_t          w_next_state;
   logic [IW-1:0]   r_rr;
   logic [CW-1:0]   r_cnt;
   logic            r_tx_start;
   logic [N-1:0]    r_tx_data;
   logic            r_done;
   logic [IW-1:0]   r_done_id;
   logic            r_err;

   logic [NREQ-1:0] w_gnt;
   logic [IW-1:0]   w_idx;
   logic            w_any;
   logic [NREQ-1:0] w_ready;
   logic            w_transfer;
   logic            w_timeout;
   logic            w_frame_done;
   logic [N-1:0]    w_sel_data;
   logic [IW-1:0]   w_rr_next;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr_arbiter (
      .req_i (req_valid_i),
      .rr_i  (r_rr),
      .gnt_o (w_gnt),
      .idx_o (w_idx),
      .any_o (w_any)
   );

   always_comb begin
      w_sel_data = '0;
      for (int p = 0; p < int'(NREQ); p++) begin
         if (IW'(p) == w_idx) begin
            w_sel_data = req_data_i[p*int'(N) +: N];
         end
      end
   end

   assign w_rr_next = IW'((32'(w_idx) + 32'd1) % NREQ);

   // State register
   always_ff @(posedge sysclk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_transfer) begin
               w_next_state = ST_START;
            end
         end
         ST_START: begin
            w_next_state = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy_i) begin
               w_next_state = ST_WAIT_DONE;
            end else if (w_timeout) begin
               w_next_state = ST_IDLE;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy_i) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Output decode; the grant is held off while the shared uart is still busy
   always_comb begin
      w_ready      = '0;
      w_transfer   = 1'b0;
      w_timeout    = 1'b0;
      w_frame_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (reset_n && !tx_busy_i && w_any) begin
               w_ready    = w_gnt;
               w_transfer = 1'b1;
            end
         end
         ST_WAIT_BUSY: begin
            w_timeout = !tx_busy_i && (r_cnt == CW'(TIMEOUT - 1));
         end
         ST_WAIT_DONE: begin
            w_frame_done = !tx_busy_i;
         end
         default: begin
         end
      endcase
   end

   // Frame latches, pulses, pointer and the saturating busy-wait counter
   always_ff @(posedge sysclk) begin
      if (!reset_n) begin
         r_rr       <= '0;
         r_cnt      <= '0;
         r_tx_start <= 1'b0;
         r_tx_data  <= '0;
         r_done     <= 1'b0;
         r_done_id  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_tx_start <= w_transfer;
         r_done     <= w_frame_done;
         if (w_transfer) begin
            r_tx_data <= w_sel_data;
            r_done_id <= w_idx;
            r_rr      <= w_rr_next;
         end
         if (r_state == ST_START) begin
            r_cnt <= '0;
         end else if ((r_state == ST_WAIT_BUSY) && !tx_busy_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign req_ready_o   = w_ready;
   assign tx_start_o    = r_tx_start;
   assign tx_data_o     = r_tx_data;
   assign done_o        = r_done;
   assign done_id_o     = r_done_id;
   assign err_timeout_o = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a uart_tx busy BFM plus a round-robin reference model
// that predicts each grant, the start pulse, frame data and done timing.
module tb_uart_tx_arbiter;

   localparam int N       = 8;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;
   // busy rises 2 cycles after the pulse, stays high 100, done follows the first low cycle
   localparam int FRAME_LAT = 2 + 100 + 1;

   logic              sysclk = 1'b0;
   logic              reset_n;
   logic [NREQ-1:0]   req_valid_i;
   logic [NREQ*N-1:0] req_data_i;
   logic [NREQ-1:0]   req_ready_o;
   logic              tx_start_o;
   logic [N-1:0]      tx_data_o;
   logic              tx_busy_i;
   logic              done_o;
   logic [1:0]        done_id_o;
   logic              err_timeout_o;

   logic [N-1:0] dat [NREQ];
   int checks = 0;
   int errors = 0;
   int model_rr = 0;

   bit bfm_en     = 1'b1;
   bit force_busy = 1'b0;
   bit bfm_busy   = 1'b0;
   int bfm_t      = 0;

   always #5 sysclk = ~sysclk;

   uart_tx_arbiter #(
      .N       (N),
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .sysclk        (sysclk),
      .reset_n       (reset_n),
      .req_valid_i   (req_valid_i),
      .req_data_i    (req_data_i),
      .req_ready_o   (req_ready_o),
      .tx_start_o    (tx_start_o),
      .tx_data_o     (tx_data_o),
      .tx_busy_i     (tx_busy_i),
      .done_o        (done_o),
      .done_id_o     (done_id_o),
      .err_timeout_o (err_timeout_o)
   );

   assign tx_busy_i = bfm_busy | force_busy;

   // uart_tx stand-in: DIV=10 with a 10-bit frame gives 100 busy cycles
   always @(negedge sysclk) begin
      if (!reset_n) begin
         bfm_t    = 0;
         bfm_busy = 1'b0;
      end else if (bfm_t > 0) begin
         bfm_t++;
         if (bfm_t == 3) bfm_busy = 1'b1;
         else if (bfm_t == 103) begin
            bfm_busy = 1'b0;
            bfm_t    = 0;
         end
      end else if (tx_start_o && bfm_en) begin
         bfm_t = 1;
      end
   end

   task automatic tick();
      @(negedge sysclk);
      #1;
   endtask

   task automatic pack_data();
      for (int i = 0; i < NREQ; i++) req_data_i[i*N +: N] = dat[i];
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int rr);
      for (int k = 0; k < NREQ; k++) begin
         if (((v >> ((rr + k) % NREQ)) & NREQ'(1)) != 0) return (rr + k) % NREQ;
      end
      return -1;
   endfunction

   // One granted frame from the IDLE cycle it is offered in to its done pulse.
   task automatic serve_frame(input string tag, input logic [NREQ-1:0] v,
                              input logic [NREQ-1:0] v_after);
      int  w;
      int  cyc;
      int  starts;
      bit  seen;
      logic [NREQ-1:0] exp_ready;
      req_valid_i = v;
      #1;
      w = pick(v, model_rr);
      exp_ready = NREQ'(1) << w;
      checks++;
      if (req_ready_o !== exp_ready) begin
         errors++;
         $display("FAIL %s grant: ready=%b expected=%b", tag, req_ready_o, exp_ready);
      end
      tick();
      req_valid_i = v_after;
      checks++;
      if (tx_start_o !== 1'b1 || tx_data_o !== dat[w] || done_id_o !== 2'(w)) begin
         errors++;
         $display("FAIL %s start: start=%b data=%h id=%0d expected start=1 data=%h id=%0d",
                  tag, tx_start_o, tx_data_o, done_id_o, dat[w], w);
      end
      checks++;
      if (tx_busy_i !== 1'b0) begin
         errors++;
         $display("FAIL %s overlap: busy=%b at start pulse expected 0", tag, tx_busy_i);
      end
      model_rr = (w + 1) % NREQ;
      cyc = 0; starts = 0; seen = 1'b0;
      while (!seen && cyc < 300) begin
         tick();
         cyc++;
         if (tx_start_o === 1'b1) starts++;
         if (done_o === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || cyc != FRAME_LAT) begin
         errors++;
         $display("FAIL %s done: seen=%0d after %0d cycles expected seen=1 after %0d",
                  tag, seen, cyc, FRAME_LAT);
      end
      checks++;
      if (starts != 0) begin
         errors++;
         $display("FAIL %s extra_start: %0d pulses expected 0", tag, starts);
      end
      checks++;
      if (tx_data_o !== dat[w] || done_id_o !== 2'(w)) begin
         errors++;
         $display("FAIL %s hold: data=%h id=%0d expected data=%h id=%0d",
                  tag, tx_data_o, done_id_o, dat[w], w);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req_valid_i = '1;
      tick();
      checks++;
      if (req_ready_o !== '0) begin
         errors++;
         $display("FAIL reset_ready: ready=%b expected 0000", req_ready_o);
      end
      tick();
      checks++;
      if (tx_start_o !== 1'b0 || tx_data_o !== '0 || done_o !== 1'b0 ||
          done_id_o !== '0 || err_timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: start=%b data=%h done=%b id=%0d err=%b expected all 0",
                  tx_start_o, tx_data_o, done_o, done_id_o, err_timeout_o);
      end
      reset_n = 1'b1;
      req_valid_i = '0;
      model_rr = 0;
      tick();
   endtask

   task automatic test_single();
      int cyc;
      bit seen;
      dat[1] = 8'hA5;
      pack_data();
      req_valid_i = 4'b0010;
      #1;
      checks++;
      if (req_ready_o !== 4'b0010) begin
         errors++;
         $display("FAIL single_ready: ready=%b expected 0010", req_ready_o);
      end
      tick();
      req_valid_i = '0;
      checks++;
      if (tx_start_o !== 1'b1 || tx_data_o !== 8'hA5) begin
         errors++;
         $display("FAIL single_start: start=%b data=%h expected start=1 data=a5", tx_start_o, tx_data_o);
      end
      tick();
      cyc = 1;
      checks++;
      if (tx_start_o !== 1'b0) begin
         errors++;
         $display("FAIL single_pulse_width: start=%b expected 0", tx_start_o);
      end
      seen = 1'b0;
      while (!seen && cyc < 300) begin
         tick();
         cyc++;
         if (done_o === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || cyc != FRAME_LAT || done_id_o !== 2'd1) begin
         errors++;
         $display("FAIL single_done: seen=%0d cyc=%0d id=%0d expected seen=1 cyc=%0d id=1",
                  seen, cyc, done_id_o, FRAME_LAT);
      end
      tick();
      checks++;
      if (done_o !== 1'b0) begin
         errors++;
         $display("FAIL single_done_width: done=%b expected 0", done_o);
      end
      model_rr = 2;
   endtask

   task automatic test_all_four();
      int order [5] = '{0, 1, 2, 3, 0};
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      model_rr = 0;
      for (int i = 0; i < NREQ; i++) dat[i] = N'($urandom);
      pack_data();
      for (int f = 0; f < 5; f++) begin
         if (f > 0) begin
            checks++;
            if (done_o !== 1'b1) begin
               errors++;
               $display("FAIL all4_grant_with_done: done=%b expected 1", done_o);
            end
         end
         serve_frame("all4", '1, '1);
         checks++;
         if (done_id_o !== 2'(order[f])) begin
            errors++;
            $display("FAIL all4_order: frame %0d id=%0d expected %0d", f, done_id_o, order[f]);
         end
      end
      req_valid_i = '0;
      tick();
   endtask

   task automatic test_wrap();
      serve_frame("wrap_pre", 4'b0100, '0);
      serve_frame("wrap_first", 4'b1001, 4'b1001);
      checks++;
      if (done_id_o !== 2'd3) begin
         errors++;
         $display("FAIL wrap_first_id: id=%0d expected 3", done_id_o);
      end
      serve_frame("wrap_second", 4'b1001, '0);
      checks++;
      if (done_id_o !== 2'd0) begin
         errors++;
         $display("FAIL wrap_second_id: id=%0d expected 0", done_id_o);
      end
   endtask

   task automatic test_timeout();
      bit done_seen;
      bfm_en = 1'b0;
      dat[0] = N'($urandom);
      pack_data();
      req_valid_i = 4'b0001;
      #1;
      checks++;
      if (req_ready_o !== 4'b0001) begin
         errors++;
         $display("FAIL timeout_ready: ready=%b expected 0001", req_ready_o);
      end
      tick();
      req_valid_i = '0;
      model_rr = 1;
      checks++;
      if (tx_start_o !== 1'b1) begin
         errors++;
         $display("FAIL timeout_start: start=%b expected 1", tx_start_o);
      end
      // last busy-wait cycle is 16 after the pulse; the flag shows the cycle after
      done_seen = 1'b0;
      for (int cyc = 1; cyc <= TIMEOUT + 1; cyc++) begin
         tick();
         if (done_o === 1'b1) done_seen = 1'b1;
         if (cyc == TIMEOUT) begin
            checks++;
            if (err_timeout_o !== 1'b0) begin
               errors++;
               $display("FAIL timeout_early: err=%b at cycle %0d expected 0", err_timeout_o, cyc);
            end
         end
      end
      checks++;
      if (err_timeout_o !== 1'b1) begin
         errors++;
         $display("FAIL timeout_flag: err=%b expected 1", err_timeout_o);
      end
      checks++;
      if (done_seen) begin
         errors++;
         $display("FAIL timeout_done: done pulsed=1 expected 0");
      end
      bfm_en = 1'b1;
      dat[1] = N'($urandom);
      pack_data();
      serve_frame("after_timeout", 4'b0010, '0);
      checks++;
      if (err_timeout_o !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: err=%b expected 1", err_timeout_o);
      end
   endtask

   task automatic test_reset_mid();
      bit done_seen;
      req_valid_i = 4'b0001;
      tick();
      req_valid_i = '0;
      for (int i = 0; i < 10; i++) tick();
      reset_n = 1'b0;
      req_valid_i = '1;
      done_seen = 1'b0;
      tick();
      if (done_o === 1'b1) done_seen = 1'b1;
      checks++;
      if (req_ready_o !== '0) begin
         errors++;
         $display("FAIL reset_mid_ready: ready=%b expected 0000", req_ready_o);
      end
      tick();
      if (done_o === 1'b1) done_seen = 1'b1;
      checks++;
      if (tx_start_o !== 1'b0 || tx_data_o !== '0 || done_id_o !== '0 || err_timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs: start=%b data=%h id=%0d err=%b expected all 0",
                  tx_start_o, tx_data_o, done_id_o, err_timeout_o);
      end
      reset_n = 1'b1;
      req_valid_i = '0;
      model_rr = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done_o === 1'b1) done_seen = 1'b1;
      end
      checks++;
      if (done_seen) begin
         errors++;
         $display("FAIL reset_mid_done: done pulsed=1 expected 0");
      end
      dat[2] = N'($urandom);
      pack_data();
      serve_frame("after_reset", 4'b0100, '0);
   endtask

   task automatic test_busy_block();
      force_busy = 1'b1;
      req_valid_i = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         #1;
         checks++;
         if (req_ready_o !== '0) begin
            errors++;
            $display("FAIL busy_block: cycle %0d ready=%b expected 0000", i, req_ready_o);
         end
         tick();
      end
      force_busy = 1'b0;
      serve_frame("busy_release", 4'b0001, '0);
   endtask

   task automatic test_random();
      logic [NREQ-1:0] v;
      int gap;
      for (int f = 0; f < 8; f++) begin
         req_valid_i = '0;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) tick();
         for (int i = 0; i < NREQ; i++) dat[i] = N'($urandom);
         pack_data();
         v = NREQ'($urandom_range(1, 15));
         serve_frame("random", v, v);
      end
      req_valid_i = '0;
      tick();
   endtask

   initial begin
      reset_n = 1'b0;
      req_valid_i = '0;
      for (int i = 0; i < NREQ; i++) dat[i] = N'($urandom);
      pack_data();
      test_reset();
      test_single();
      test_all_four();
      test_wrap();
      test_timeout();
      test_reset_mid();
      test_busy_block();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
